commit_event_queue: RTL
=======================

// Module: commit_event_queue
// PURPOSE
//  Multi-lane commit trace buffer between the pipeline writeback stage and the
//  DifftestInstrCommit / DifftestTrapEvent ports.
//  Accepts up to NCH retired instructions per cycle and stores them in a circular queue.
//  Replays them in program order, up to NCH per cycle, to the difftest side.
//  Also generates the core's post-reset start pulse and keeps instruction and cycle counters.
// PARAMETERS
//  NCH       2   commit lanes in and out; 1 <= NCH <= DEPTH
//  DEPTH     8   queue entries; power of two
//  XLEN      64  pc/data width
//  RST_PULSE 1   core_rst high time in cycles; >= 1
// PORTS
//  clk        in   1         clock, rising edge
//  reset      in   1         asynchronous, active-high reset
//  core_rst   out  1         start pulse to core
//  in_valid   in   NCH       per-lane commit valid; any pattern allowed
//  in_pc      in   NCH*XLEN  per-lane committed pc
//  in_inst    in   NCH*32    per-lane instruction word
//  in_skip    in   NCH       per-lane difftest skip
//  in_wen     in   NCH       per-lane rd write enable
//  in_wdest   in   NCH*5     per-lane rd index
//  in_wdata   in   NCH*XLEN  per-lane rd data
//  in_ready   out  1         queue can take NCH entries this cycle
//  out_valid  out  NCH       thermometer: lanes 0..k-1 valid
//  out_pc/out_inst/out_skip/out_wen/out_wdest/out_wdata  out  as in_*  oldest-first entries
//  out_ready  in   1         consumer takes every valid out lane this cycle
//  instr_cnt  out  64        total entries popped
//  cycle_cnt  out  64        cycles since core_rst fell
//  overflow   out  1         sticky: a push was dropped
// BEHAVIOUR
//  Reset (async, takes effect immediately):
//   - core_rst=0, count=0, head=tail=0, instr_cnt=0, cycle_cnt=0, overflow=0.
//   - out_valid=0, in_ready=0; pulse counter cleared.
//  Start pulse:
//   - core_rst goes 1 at the first clk edge after reset falls.
//   - Held for exactly RST_PULSE cycles, then 0 until the next reset.
//   - While core_rst=1: in_ready=0, pushes ignored (no overflow), queue held empty.
//  Push:
//   - in_ready = !core_rst && (DEPTH - count) >= NCH, from registered count.
//   - Same-cycle pops do not count toward in_ready.
//   - When in_ready: valid lanes are compacted in ascending lane order and written at tail.
//   - A lane with in_valid=0 is never stored; tail advances by popcount(in_valid) mod DEPTH.
//   - If any in_valid=1 while in_ready=0 and core_rst=0: the whole group is dropped and
//     overflow is set to 1, cleared only by reset.
//  Output:
//   - Registered: an entry written at edge t is visible at out_* after edge t (1-cycle latency).
//   - k = min(count, NCH). Lane j shows entry at (head+j) mod DEPTH; out_valid[j] = (j < k).
//   - out_wen = stored wen && wdest != 0 (x0 writes suppressed).
//   - Lanes with out_valid=0 drive all fields 0.
//  Pop:
//   - When out_ready=1, k entries are removed; head advances by k mod DEPTH.
//   - instr_cnt += k.
//  Simultaneous push and pop: count_next = count + pushed - popped.
//   - Never exceeds DEPTH, never goes below 0.
//  Counters and pointers:
//   - Pointers are log2(DEPTH) bits and wrap naturally.
//   - cycle_cnt += 1 every cycle with core_rst=0, starting after the pulse.
//   - instr_cnt and cycle_cnt wrap modulo 2^64.
//  Reset mid-operation: contents discarded, all state as reset; the start pulse repeats.
// TESTING (NCH=2, DEPTH=8, RST_PULSE=1 unless noted)
//  T1 Reset release:
//   - core_rst=1 exactly one cycle; cycle_cnt=0 in that cycle, 1 the next.
//   - Repeat with RST_PULSE=3: core_rst=1 for 3 cycles.
//  T2 Compaction:
//   - Push in_valid=2'b10 pc=0x8000_0004; next cycle out_valid=2'b01, out_pc[0]=0x8000_0004.
//   - Pop: instr_cnt=1.
//  T3 Ordering: push {0x100,0x104} then {0x108,-}, out_ready=0.
//   - Lanes show 0x100,0x104; after pop show 0x108 alone.
//   - instr_cnt=3 after both pops.
//  T4 Full:
//   - count=6: in_ready=1. count=7: in_ready=0.
//   - Push 2'b11 at count=7: count stays 7, overflow=1 until reset.
//  T5 Wrap:
//   - Stream 40 entries with random out_ready.
//   - Out order equals in order; head/tail wrap; instr_cnt=40.
//  T6 Edge cases:
//   - Push wen=1 wdest=0: out_wen=0.
//   - Assert reset with count=5: out_valid=0, instr_cnt=0, overflow=0 immediately; pulse repeats.

Source files
------------

// File: rtl/commit_event_queue.sv
// commit_event_queue
// Circular commit trace buffer sitting between writeback and the difftest ports.
// Takes up to NCH retired instructions per cycle, compacts the valid lanes and
// replays them oldest-first, up to NCH per cycle. Also produces the core start
// pulse after reset and keeps retired-instruction and cycle counters.
module commit_event_queue #(
    parameter int NCH       = 2,
    parameter int DEPTH     = 8,
    parameter int XLEN      = 64,
    parameter int RST_PULSE = 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic                core_rst,
    input  logic [NCH-1:0]      in_valid,
    input  logic [NCH*XLEN-1:0] in_pc,
    input  logic [NCH*32-1:0]   in_inst,
    input  logic [NCH-1:0]      in_skip,
    input  logic [NCH-1:0]      in_wen,
    input  logic [NCH*5-1:0]    in_wdest,
    input  logic [NCH*XLEN-1:0] in_wdata,
    output logic                in_ready,
    output logic [NCH-1:0]      out_valid,
    output logic [NCH*XLEN-1:0] out_pc,
    output logic [NCH*32-1:0]   out_inst,
    output logic [NCH-1:0]      out_skip,
    output logic [NCH-1:0]      out_wen,
    output logic [NCH*5-1:0]    out_wdest,
    output logic [NCH*XLEN-1:0] out_wdata,
    input  logic                out_ready,
    output logic [63:0]         instr_cnt,
    output logic [63:0]         cycle_cnt,
    output logic                overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PUL_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_RUN   = 2'd2
    } phase_t;

    phase_t             phase_q, phase_d;
    logic [PUL_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [63:0]        instr_cnt_q, instr_cnt_d;
    logic [63:0]        cycle_cnt_q, cycle_cnt_d;
    logic               overflow_q, overflow_d;

    logic [XLEN-1:0]    mem_pc_q    [DEPTH];
    logic [XLEN-1:0]    mem_pc_d    [DEPTH];
    logic [31:0]        mem_inst_q  [DEPTH];
    logic [31:0]        mem_inst_d  [DEPTH];
    logic               mem_skip_q  [DEPTH];
    logic               mem_skip_d  [DEPTH];
    logic               mem_wen_q   [DEPTH];
    logic               mem_wen_d   [DEPTH];
    logic [4:0]         mem_wdest_q [DEPTH];
    logic [4:0]         mem_wdest_d [DEPTH];
    logic [XLEN-1:0]    mem_wdata_q [DEPTH];
    logic [XLEN-1:0]    mem_wdata_d [DEPTH];

    logic [CNT_W-1:0]   pop_k;
    logic [CNT_W-1:0]   popped;
    logic [CNT_W-1:0]   push_n;
    logic [PTR_W-1:0]   push_offs;
    logic [PTR_W-1:0]   widx;
    logic [PTR_W-1:0]   ridx;

    assign core_rst  = (phase_q == S_PULSE);
    assign in_ready  = (phase_q == S_RUN) && (count_q <= CNT_W'(DEPTH - NCH));
    assign pop_k     = (count_q < CNT_W'(NCH)) ? count_q : CNT_W'(NCH);
    assign instr_cnt = instr_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
    assign overflow  = overflow_q;

    // Start-pulse sequencer: idle until the first edge after reset, pulse, then run forever
    always_comb begin
        phase_d     = phase_q;
        pulse_cnt_d = pulse_cnt_q;
        case (phase_q)
            S_IDLE: begin
                phase_d     = S_PULSE;
                pulse_cnt_d = '0;
            end
            S_PULSE: begin
                if (pulse_cnt_q == PUL_W'(RST_PULSE - 1)) begin
                    phase_d = S_RUN;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PUL_W'(1);
                end
            end
            S_RUN: begin
                phase_d = S_RUN;
            end
            default: begin
                phase_d = S_IDLE;
            end
        endcase
    end

    // Queue update: compact valid lanes into the tail, retire k entries from the head
    always_comb begin
        mem_pc_d    = mem_pc_q;
        mem_inst_d  = mem_inst_q;
        mem_skip_d  = mem_skip_q;
        mem_wen_d   = mem_wen_q;
        mem_wdest_d = mem_wdest_q;
        mem_wdata_d = mem_wdata_q;
        push_n      = '0;
        push_offs   = '0;
        widx        = '0;
        for (int i = 0; i < NCH; i++) begin
            if (in_ready && in_valid[i]) begin
                widx              = tail_q + push_offs;
                mem_pc_d[widx]    = in_pc[i*XLEN +: XLEN];
                mem_inst_d[widx]  = in_inst[i*32 +: 32];
                mem_skip_d[widx]  = in_skip[i];
                mem_wen_d[widx]   = in_wen[i];
                mem_wdest_d[widx] = in_wdest[i*5 +: 5];
                mem_wdata_d[widx] = in_wdata[i*XLEN +: XLEN];
                push_offs         = push_offs + PTR_W'(1);
                push_n            = push_n + CNT_W'(1);
            end
        end
        popped      = out_ready ? pop_k : '0;
        count_d     = count_q + push_n - popped;
        tail_d      = tail_q + push_offs;
        head_d      = head_q + PTR_W'(popped);
        instr_cnt_d = instr_cnt_q + 64'(popped);
        cycle_cnt_d = (phase_d == S_RUN) ? cycle_cnt_q + 64'd1 : cycle_cnt_q;
        overflow_d  = overflow_q | ((|in_valid) & ~in_ready & ~core_rst);
    end

    // Output lanes: the k oldest entries, unused lanes forced to zero, x0 writes hidden
    always_comb begin
        out_valid = '0;
        out_pc    = '0;
        out_inst  = '0;
        out_skip  = '0;
        out_wen   = '0;
        out_wdest = '0;
        out_wdata = '0;
        ridx      = '0;
        for (int j = 0; j < NCH; j++) begin
            if (CNT_W'(j) < pop_k) begin
                ridx                    = head_q + PTR_W'(j);
                out_valid[j]            = 1'b1;
                out_pc[j*XLEN +: XLEN]  = mem_pc_q[ridx];
                out_inst[j*32 +: 32]    = mem_inst_q[ridx];
                out_skip[j]             = mem_skip_q[ridx];
                out_wen[j]              = mem_wen_q[ridx] && (mem_wdest_q[ridx] != 5'd0);
                out_wdest[j*5 +: 5]     = mem_wdest_q[ridx];
                out_wdata[j*XLEN +: XLEN] = mem_wdata_q[ridx];
            end
        end
    end

    // Control and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= S_IDLE;
            pulse_cnt_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            pulse_cnt_q <= pulse_cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // Entry storage; cleared on reset so a restarted run never replays stale data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_pc_q[e]    <= '0;
                mem_inst_q[e]  <= '0;
                mem_skip_q[e]  <= 1'b0;
                mem_wen_q[e]   <= 1'b0;
                mem_wdest_q[e] <= '0;
                mem_wdata_q[e] <= '0;
            end
        end else begin
            mem_pc_q    <= mem_pc_d;
            mem_inst_q  <= mem_inst_d;
            mem_skip_q  <= mem_skip_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdest_q <= mem_wdest_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule
